// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache, 4-word lines, zero-latency hit and a blocking line refill.
// Define ICACHE_STATS_EN to add the hitCount/missCount statistics outputs.
module instruction_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [31:0] pcAddress,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        memReadRequest,
    output logic [31:0] memAddress,
    input  logic [31:0] memReadData,
    input  logic        memReadValid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;
    state_t state, nextState;

    logic [31:0]          dataArray [LINES][4];
    logic [TAG_BITS-1:0]  tagArray  [LINES];
    logic [LINES-1:0]     validBits;
    logic [1:0]           beatCount;
    logic                 flushSeen;
    logic [31:0]          missAddress;

    logic [1:0]            pcOffset;
    logic [INDEX_BITS-1:0] pcIndex, missIndex;
    logic [TAG_BITS-1:0]   pcTag, missTag;
    logic                  lookupHit, finalBeat;
    logic                  unusedPcBits;

    assign pcOffset     = pcAddress[3:2];
    assign pcIndex      = pcAddress[3+INDEX_BITS:4];
    assign pcTag        = pcAddress[31:4+INDEX_BITS];
    assign missIndex    = missAddress[3+INDEX_BITS:4];
    assign missTag      = missAddress[31:4+INDEX_BITS];
    assign unusedPcBits = ^pcAddress[1:0];

    // A flush in the same cycle hides the hit even though valid bits clear only at the edge.
    assign lookupHit = (state == IDLE) && !flush && validBits[pcIndex] && (tagArray[pcIndex] == pcTag);
    assign finalBeat = (state == REFILL) && memReadValid && (beatCount == 2'd3);
    assign memAddress = missAddress;

    always_ff @(posedge clock) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState      = state;
        hit            = lookupHit;
        instruction    = '0;
        memReadRequest = (state == REFILL);
        if (lookupHit) instruction = dataArray[pcIndex][pcOffset];
        case (state)
            IDLE:    if (!lookupHit) nextState = REFILL;
            REFILL:  if (finalBeat)  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            beatCount   <= 2'd0;
            flushSeen   <= 1'b0;
            missAddress <= '0;
        end else if (state == IDLE) begin
            beatCount <= 2'd0;
            flushSeen <= 1'b0;
            if (nextState == REFILL) missAddress <= {pcAddress[31:4], 4'b0000};
        end else begin
            if (memReadValid) beatCount <= beatCount + 2'd1;
            if (flush)        flushSeen <= 1'b1;
        end
    end

    // Flush has priority, so a flush on the final beat leaves the new line invalid.
    always_ff @(posedge clock) begin
        if (!resetN)                      validBits <= '0;
        else if (flush)                   validBits <= '0;
        else if (finalBeat && !flushSeen) validBits[missIndex] <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (resetN && state == REFILL && memReadValid) begin
            dataArray[missIndex][beatCount] <= memReadData;
            if (beatCount == 2'd3) tagArray[missIndex] <= missTag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clock) begin
        if (!resetN) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (lookupHit && hitCount != 32'hFFFF_FFFF) hitCount <= hitCount + 32'd1;
            if (state == IDLE && nextState == REFILL && missCount != 32'hFFFF_FFFF)
                missCount <= missCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed sequences, a vector table and
// randomized fetches checked against a line-residency model.
module tb_instruction_cache;
  logic        clock;
  logic        resetN;
  logic [31:0] pcAddress;
  logic        flush;
  logic [31:0] instruction;
  logic        hit;
  logic        memReadRequest;
  logic [31:0] memAddress;
  logic [31:0] memReadData;
  logic        memReadValid;
`ifdef ICACHE_STATS_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  int tests = 0;
  int fails = 0;

  // Model: which memory line sits at each index, and the base word of its contents.
  logic [27:0] resLine[int];
  logic [31:0] resBase[int];

  typedef struct {
    logic [31:0] pc;
    logic        expHit;
    logic [31:0] expInstr;
  } vec_t;
  vec_t vecs[6];

  instruction_cache #(.INDEX_BITS(4)) dut (
    .clock(clock),
    .resetN(resetN),
    .pcAddress(pcAddress),
    .flush(flush),
    .instruction(instruction),
    .hit(hit),
    .memReadRequest(memReadRequest),
    .memAddress(memAddress),
    .memReadData(memReadData),
    .memReadValid(memReadValid)
`ifdef ICACHE_STATS_EN
    ,
    .hitCount(hitCount),
    .missCount(missCount)
`endif
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    resLine.delete();
    resBase.delete();
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    flush = 1'b0;
    memReadValid = 1'b0;
    nextCycle();
    nextCycle();
    #2;
    check("rstHit", 32'(hit), 32'd0);
    check("rstInstr", instruction, 32'd0);
    check("rstReq", 32'(memReadRequest), 32'd0);
    check("rstAddr", memAddress, 32'd0);
    nextCycle();
    resetN = 1'b1;
    clearModel();
  endtask

  // driver: serves one line refill, entered just after the edge that moved the DUT into refill
  task automatic runRefill(input logic [31:0] line, input logic [31:0] base, input int maxGap,
                           input int flushBeat, input bit randPc);
    int beat = 0;
    int guard = 0;
    bit flushed = 0;
    while (beat < 4 && guard < 200) begin
      memReadValid = (maxGap == 0) ? 1'b1 : ($urandom_range(0, maxGap) == 0);
      memReadData = memReadValid ? base + 32'(beat) : $urandom;
      flush = memReadValid && (beat == flushBeat);
      if (flush) flushed = 1;
      if (randPc) pcAddress = $urandom;
      #2;
      check("refillReq", 32'(memReadRequest), 32'd1);
      check("refillAddr", memAddress, line);
      check("refillHit", 32'(hit), 32'd0);
      if (memReadValid) beat++;
      guard++;
      nextCycle();
    end
    memReadValid = 1'b0;
    flush = 1'b0;
    if (beat < 4) begin
      tests++;
      fails++;
      $display("FAIL refillTimeout: got %0d beats expected 4", beat);
    end
    if (flushed) clearModel();
    else begin
      resLine[int'(line[7:4])] = line[31:4];
      resBase[int'(line[7:4])] = base;
    end
  endtask

  // one fetch transaction: IDLE lookup, and a refill if the model predicts a miss
  task automatic lookup(input logic [31:0] pc, input logic fl, input logic [31:0] base,
                        input int maxGap, input int flushBeat, input bit randPc);
    int idx;
    bit expHit;
    idx = int'(pc[7:4]);
    expHit = !fl && resLine.exists(idx) && (resLine[idx] == pc[31:4]);
    pcAddress = pc;
    flush = fl;
    memReadValid = 1'($urandom_range(0, 1));
    memReadData = $urandom;
    #2;
    check("lookupHit", 32'(hit), 32'(expHit));
    check("lookupReq", 32'(memReadRequest), 32'd0);
    if (expHit) check("lookupInstr", instruction, resBase[idx] + 32'(pc[3:2]));
    else        check("lookupInstrMiss", instruction, 32'd0);
    nextCycle();
    flush = 1'b0;
    memReadValid = 1'b0;
    if (!expHit) begin
      if (fl) clearModel();
      runRefill({pc[31:4], 4'b0000}, base, maxGap, flushBeat, randPc);
    end
  endtask

  initial begin
    logic [31:0] pc;
    resetN = 1'b0;
    pcAddress = '0;
    flush = 1'b0;
    memReadValid = 1'b0;
    memReadData = '0;

    vecs[0] = '{32'h0000_0040, 1'b1, 32'h0000_00A0};
    vecs[1] = '{32'h0000_0043, 1'b1, 32'h0000_00A0};
    vecs[2] = '{32'h0000_0044, 1'b1, 32'h0000_00A1};
    vecs[3] = '{32'h0000_004A, 1'b1, 32'h0000_00A2};
    vecs[4] = '{32'h0000_004C, 1'b1, 32'h0000_00A3};
    vecs[5] = '{32'h0000_004F, 1'b1, 32'h0000_00A3};

    nextCycle();
    applyReset();

    // cold miss then hit on the first word
    lookup(32'h0000_0040, 1'b0, 32'h0000_00A0, 0, -1, 0);
    for (int i = 0; i < 3; i++) lookup(32'h0000_0040, 1'b0, 32'h0, 0, -1, 0);
`ifdef ICACHE_STATS_EN
    #2;
    check("missCount", missCount, 32'd1);
    check("hitCount", hitCount, 32'd3);
`endif

    // same-line hits from the vector table; stray memReadValid in IDLE must be ignored
    foreach (vecs[i]) begin
      pcAddress = vecs[i].pc;
      memReadValid = 1'b1;
      memReadData = $urandom;
      #2;
      check("vecHit", 32'(hit), 32'(vecs[i].expHit));
      check("vecInstr", instruction, vecs[i].expInstr);
      check("vecReq", 32'(memReadRequest), 32'd0);
      nextCycle();
    end
    memReadValid = 1'b0;

    // conflict eviction on index 4
    lookup(32'h0000_0140, 1'b0, 32'h0000_00B0, 0, -1, 0);
    lookup(32'h0000_0148, 1'b0, 32'h0, 0, -1, 0);
    lookup(32'h0000_0040, 1'b0, 32'h0000_00A0, 1, -1, 0);

    // flush during refill (beat 1) and on the final beat, then refetch
    lookup(32'h0000_0080, 1'b0, 32'h0000_0E00, 0, 1, 0);
    lookup(32'h0000_0080, 1'b0, 32'h0000_0E10, 0, 3, 0);
    lookup(32'h0000_0084, 1'b0, 32'h0000_0E20, 0, -1, 1);
    lookup(32'h0000_0084, 1'b0, 32'h0, 0, -1, 0);

    // flush in IDLE hides a resident line and evicts everything
    lookup(32'h0000_0088, 1'b1, 32'h0000_0D00, 0, -1, 0);
    lookup(32'h0000_0088, 1'b0, 32'h0, 0, -1, 0);
    lookup(32'h0000_0040, 1'b0, 32'h0000_00A0, 0, -1, 0);

    // reset in the middle of a refill
    applyReset();
    pcAddress = 32'h0000_0040;
    #2;
    check("midRstMiss", 32'(hit), 32'd0);
    nextCycle();
    for (int b = 0; b < 3; b++) begin
      memReadValid = 1'b1;
      memReadData = 32'h0000_00C0 + 32'(b);
      nextCycle();
    end
    resetN = 1'b0;
    memReadData = 32'h0000_00C3;
    nextCycle();
    #2;
    check("midRstReq", 32'(memReadRequest), 32'd0);
    check("midRstHit", 32'(hit), 32'd0);
    check("midRstAddr", memAddress, 32'd0);
    nextCycle();
    #2;
    check("midRstReq2", 32'(memReadRequest), 32'd0);
    nextCycle();
    resetN = 1'b1;
    memReadValid = 1'b0;
    clearModel();
    lookup(32'h0000_0040, 1'b0, 32'h0000_00A0, 0, -1, 0);
    lookup(32'h0000_004C, 1'b0, 32'h0, 0, -1, 0);

    // randomized fetch stream over a few indices and tags
    for (int i = 0; i < 150; i++) begin
      int fb;
      pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      lookup(pc, 1'($urandom_range(0, 15) == 0), $urandom, int'($urandom_range(0, 2)), fb,
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
